limitador_tentativas: RTL

- Parametrised failed-attempt limiter for the card/PIN access path.
- Counts comparator failure events inside a sliding time window of `JANELA` clock cycles.
- Asserts `ejeta` (card eject / lockout) when a failure arrives while `MAX_TENT` failures are already live in the window.
- Sits between the PIN comparator and the card mechanism controller. It is the fully synchronous, multi-slot successor of the 3-slot attempt counter.

---
 rtl/limitador_pkg.sv | 17 +
 rtl/slot_tentativa.sv | 31 +++
 rtl/limitador_tentativas.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/limitador_pkg.sv
// rtl/limitador_pkg.sv - shared state type and width helpers for the failed-attempt limiter
package limitador_pkg;

    typedef enum logic [0:0] {
        ATIVO   = 1'b0,
        EJETADO = 1'b1
    } estado_t;

    function automatic int largura_janela(input int janela);
        return $clog2(janela + 1);
    endfunction

    function automatic int largura_contagem(input int max_tent);
        return $clog2(max_tent + 1);
    endfunction

endpackage

// File: rtl/slot_tentativa.sv
// rtl/slot_tentativa.sv - one failure slot: saturating down-counter, free when zero
module slot_tentativa
    import limitador_pkg::*;
#(
    parameter int JANELA = 15
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              carregar,
    input  logic                              limpar,
    output logic [largura_janela(JANELA)-1:0] valor,
    output logic                              livre
);

    localparam int            JW    = largura_janela(JANELA);
    localparam logic [JW-1:0] CARGA = JW'(JANELA);
    localparam logic [JW-1:0] UM    = JW'(1);

    always_ff @(posedge clk) begin
        if (rst || limpar) begin
            valor <= '0;
        end else if (carregar) begin
            valor <= CARGA;
        end else if (valor != '0) begin
            valor <= valor - UM;
        end
    end

    assign livre = (valor == '0);

endmodule

// File: rtl/limitador_tentativas.sv
// rtl/limitador_tentativas.sv - sliding-window failure limiter with lockout; LIMITADOR_TIMEOUT_BLOQUEIO_EN adds lockout timeout
module limitador_tentativas
    import limitador_pkg::*;
#(
    parameter int MAX_TENT = 3,
    parameter int JANELA   = 15,
    parameter int BLOQUEIO = 255
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  saidaComparador,
    input  logic                                  acerto,
    input  logic                                  liberar,
    output logic                                  ejeta,
    output logic [largura_contagem(MAX_TENT)-1:0] tentativas_ativas
);

    localparam int            JW     = largura_janela(JANELA);
    localparam int            CW     = largura_contagem(MAX_TENT);
    localparam logic [JW-1:0] JW_UM  = JW'(1);

    if (MAX_TENT < 1) begin : g_erro_max_tent
        $error("MAX_TENT must be >= 1");
    end
    if (JANELA < 1) begin : g_erro_janela
        $error("JANELA must be >= 1");
    end
    if (BLOQUEIO < 1) begin : g_erro_bloqueio
        $error("BLOQUEIO must be >= 1");
    end

    estado_t             estado;
    logic                sai_q;
    logic                evento;
    logic                ativo;
    logic                aceita;
    logic                zera;
    logic                ev_valido;
    logic                tem_livre;
    logic                entra_bloqueio;
    logic [MAX_TENT-1:0] livre_v;
    logic [MAX_TENT-1:0] alvo;
    logic [MAX_TENT-1:0] carregar_v;
    logic [MAX_TENT-1:0] limpar_v;
    logic [MAX_TENT-1:0] prox_vivo;
    logic [JW-1:0]       valor_v [MAX_TENT];
    logic [CW-1:0]       soma;

    assign evento    = saidaComparador & ~sai_q;
    assign ativo     = (estado == ATIVO);
    // liberar outranks acerto and events, so neither is processed on a release edge
    assign aceita    = ativo & ~liberar;
    assign zera      = aceita & acerto;
    assign ev_valido = aceita & evento;
    assign tem_livre = |livre_v;
    assign entra_bloqueio = ev_valido & ~zera & ~tem_livre;

    always_comb begin
        alvo = '0;
        for (int i = MAX_TENT - 1; i >= 0; i--) begin
            if (livre_v[i]) begin
                alvo    = '0;
                alvo[i] = 1'b1;
            end
        end
    end

    // after acerto the pool is empty, so a same-cycle event lands in slot 0
    always_comb begin
        carregar_v = '0;
        limpar_v   = '0;
        if (!ativo || entra_bloqueio) begin
            limpar_v = '1;
        end else if (zera) begin
            carregar_v[0] = ev_valido;
            limpar_v      = ~carregar_v;
        end else if (ev_valido) begin
            carregar_v = alvo;
        end
    end

    for (genvar i = 0; i < MAX_TENT; i++) begin : g_slot
        slot_tentativa #(
            .JANELA (JANELA)
        ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .carregar (carregar_v[i]),
            .limpar   (limpar_v[i]),
            .valor    (valor_v[i]),
            .livre    (livre_v[i])
        );
    end

    // count is taken from the slot values about to be written, so it moves on the same edge
    always_comb begin
        prox_vivo = '0;
        soma      = '0;
        for (int i = 0; i < MAX_TENT; i++) begin
            prox_vivo[i] = ~limpar_v[i] & (carregar_v[i] | (valor_v[i] > JW_UM));
            soma         = soma + CW'(prox_vivo[i]);
        end
    end

`ifdef LIMITADOR_TIMEOUT_BLOQUEIO_EN
    localparam int            BW      = largura_contagem(BLOQUEIO);
    localparam logic [BW-1:0] B_CARGA = BW'(BLOQUEIO);
    localparam logic [BW-1:0] B_UM    = BW'(1);

    logic [BW-1:0] cont_bloq;

    always_ff @(posedge clk) begin
        if (rst) begin
            cont_bloq <= '0;
        end else if (entra_bloqueio) begin
            cont_bloq <= B_CARGA;
        end else if (!ativo && cont_bloq != '0) begin
            cont_bloq <= cont_bloq - B_UM;
        end
    end
`endif

    // the edge register also tracks during reset: a level already high at release is not an event
    always_ff @(posedge clk) begin
        sai_q <= saidaComparador;
        if (rst) begin
            estado            <= ATIVO;
            tentativas_ativas <= '0;
        end else begin
            tentativas_ativas <= soma;
            if (liberar) begin
                estado <= ATIVO;
            end else if (entra_bloqueio) begin
                estado <= EJETADO;
`ifdef LIMITADOR_TIMEOUT_BLOQUEIO_EN
            end else if (!ativo && cont_bloq == B_UM) begin
                estado <= ATIVO;
`endif
            end
        end
    end

    assign ejeta = (estado == EJETADO);

endmodule
